// File: rtl/matrix_mac_sequencer_if.sv
// rtl/matrix_mac_sequencer_if.sv - bank read side and result stream of the 3x3 MAC sequencer
interface matrix_mac_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 2 * DATA_W + 2
);
    logic              start;
    logic [DATA_W-1:0] data_w1;
    logic [DATA_W-1:0] data_w2;
    logic [DATA_W-1:0] data_w3;
    logic [DATA_W-1:0] data_x1;
    logic [DATA_W-1:0] data_x2;
    logic [DATA_W-1:0] data_x3;
    logic              unload1;
    logic              unload2;
    logic              unload3;
    logic [ACC_W-1:0]  c_data;
    logic [3:0]        c_index;
    logic              c_valid;
    logic              c_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3, c_ready,
        output unload1, unload2, unload3, c_data, c_index, c_valid, busy, done
    );

    modport slave (
        output start, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3, c_ready,
        input  unload1, unload2, unload3, c_data, c_index, c_valid, busy, done
    );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// rtl/matrix_mac_sequencer.sv - steps the matrix bank, accumulates C = W*X, streams C row-major
module matrix_mac_sequencer #(
    parameter int DATA_W        = 4,
    parameter int ACC_W         = 2 * DATA_W + 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     clear_n,
    matrix_mac_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_q;
    logic [2:0]          settle_cnt;
    logic [3:0]          c_index_q;
    logic [ACC_W-1:0]    acc [9];
    logic [2*DATA_W-1:0] prod [9];
    logic [DATA_W-1:0]   w_col [3];
    logic [DATA_W-1:0]   x_row [3];
    logic                launch;
    logic                in_step;
    logic                step_last;
    logic                accept;

    assign w_col[0] = bus.data_w1;
    assign w_col[1] = bus.data_w2;
    assign w_col[2] = bus.data_w3;
    assign x_row[0] = bus.data_x1;
    assign x_row[1] = bus.data_x2;
    assign x_row[2] = bus.data_x3;

    // Outer product of the current W column and X row, full 2*DATA_W precision
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                prod[3*i+j] = (2*DATA_W)'(w_col[i]) * (2*DATA_W)'(x_row[j]);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        in_step     = (state == STEP1) || (state == STEP2) || (state == STEP3);
        step_last   = in_step && (settle_cnt == 3'(SETTLE_CYCLES));
        accept      = (state == OUT) && bus.c_ready;
        bus.unload1 = (state == STEP1);
        bus.unload2 = (state == STEP2);
        bus.unload3 = (state == STEP3);
        bus.c_valid = (state == OUT);
        bus.busy    = in_step || (state == OUT);
        bus.done    = (state == DONE);
        bus.c_index = c_index_q;
        bus.c_data  = (state == OUT) ? acc[c_index_q] : '0;
        case (state)
            IDLE: begin
                if (bus.start && !start_q) begin
                    state_nxt = STEP1;
                    launch    = 1'b1;
                end
            end
            STEP1:   if (step_last) state_nxt = STEP2;
            STEP2:   if (step_last) state_nxt = STEP3;
            STEP3:   if (step_last) state_nxt = OUT;
            OUT:     if (accept && (c_index_q == 4'd8)) state_nxt = DONE;
            DONE:    if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            settle_cnt <= '0;
            c_index_q  <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.start;
            if (step_last || !in_step) begin
                settle_cnt <= '0;
            end else begin
                settle_cnt <= settle_cnt + 3'd1;
            end
            if (launch) begin
                c_index_q <= '0;
            end else if (accept) begin
                c_index_q <= (c_index_q == 4'd8) ? 4'd0 : c_index_q + 4'd1;
            end
        end
    end

    // Products wrap into ACC_W bits when the accumulator is configured narrow
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int k = 0; k < 9; k++) acc[k] <= '0;
        end else if (launch) begin
            for (int k = 0; k < 9; k++) acc[k] <= '0;
        end else if (step_last) begin
            for (int k = 0; k < 9; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
        end
    end
endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// tb/tb_matrix_mac_sequencer.sv - scoreboard bench, SETTLE_CYCLES=1 and =3 instances in lockstep
module tb_matrix_mac_sequencer;
    localparam int ACC_W = 10;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       start = 1'b0;
    logic       c_ready = 1'b1;
    logic [3:0] garbage = '0;
    logic [3:0] W [3][3];
    logic [3:0] X [3][3];
    int         ready_mode = 0;
    int         rcnt = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       exp_q [2][$];

    logic [1:0] valid_v, busy_v, done_v, u1_v, u2_v, u3_v;
    logic [3:0] cidx_v [2];
    logic [9:0] cdata_v [2];

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) garbage <= 4'($urandom);

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int SC = (g == 0) ? 1 : 3;
        matrix_mac_sequencer_if #(.DATA_W(4)) bus ();
        logic [2:0] prev_u;
        logic [2:0] unl;
        int         run;

        matrix_mac_sequencer #(.DATA_W(4), .SETTLE_CYCLES(SC)) dut (
            .clk     (clk),
            .clear_n (clear_n),
            .bus     (bus)
        );

        assign bus.start   = start;
        assign bus.c_ready = c_ready;
        assign valid_v[g]  = bus.c_valid;
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign u1_v[g]     = bus.unload1;
        assign u2_v[g]     = bus.unload2;
        assign u3_v[g]     = bus.unload3;
        assign cidx_v[g]   = bus.c_index;
        assign cdata_v[g]  = bus.c_data;

        // Bank model: selected column of W and row of X, noise otherwise
        always_comb begin
            bus.data_w1 = garbage;
            bus.data_w2 = ~garbage;
            bus.data_w3 = garbage;
            bus.data_x1 = ~garbage;
            bus.data_x2 = garbage;
            bus.data_x3 = ~garbage;
            for (int k = 0; k < 3; k++) begin
                if ((k == 0 && bus.unload1) || (k == 1 && bus.unload2) || (k == 2 && bus.unload3)) begin
                    bus.data_w1 = W[0][k];
                    bus.data_w2 = W[1][k];
                    bus.data_w3 = W[2][k];
                    bus.data_x1 = X[k][0];
                    bus.data_x2 = X[k][1];
                    bus.data_x3 = X[k][2];
                end
            end
        end

        always @(negedge clk) begin
            if (!clear_n) begin
                prev_u = '0;
                run    = 0;
            end else begin
                unl = {bus.unload3, bus.unload2, bus.unload1};
                check($sformatf("onehot_%0d", g), int'($countones(unl) <= 1), 1);
                if (prev_u != 0 && unl != prev_u) check($sformatf("unload_len_%0d", g), run, SC + 1);
                run    = (unl == 0) ? 0 : ((unl == prev_u) ? run + 1 : 1);
                prev_u = unl;
                if (bus.c_valid) begin
                    check($sformatf("unload_in_out_%0d", g), int'(unl), 0);
                    check($sformatf("busy_in_out_%0d", g), int'(bus.busy), 1);
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_out_%0d", g), int'(bus.c_index), -1);
                    end else begin
                        check($sformatf("c_index_%0d", g), int'(bus.c_index), exp_q[g][0].idx);
                        check($sformatf("c_data_%0d", g), int'(bus.c_data), exp_q[g][0].data);
                        if (bus.c_ready) void'(exp_q[g].pop_front());
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       c_ready = 1'b1;
            1:       begin c_ready = (rcnt % 3 == 0); rcnt++; end
            default: c_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    int sum = 0;
                    for (int k = 0; k < 3; k++) sum += int'(W[i][k]) * int'(X[k][j]);
                    exp_q[g].push_back('{idx: 3 * i + j, data: sum % (1 << ACC_W)});
                end
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_v != 2'b11 && n < 300) begin
            tick();
            n++;
        end
        check("done_reached", int'(done_v), 3);
        check("drained_0", exp_q[0].size(), 0);
        check("drained_1", exp_q[1].size(), 0);
    endtask

    task automatic run_one();
        start = 1'b0;
        tick();
        tick();
        push_model();
        start = 1'b1;
        wait_done();
    endtask

    task automatic check_quiet(string name);
        check({name, "_unload"}, int'(u1_v | u2_v | u3_v), 0);
        check({name, "_valid"}, int'(valid_v), 0);
        check({name, "_busy"}, int'(busy_v), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                W[i][j] = 4'(3 * i + j + 1);
                X[i][j] = 4'd1;
            end
        repeat (3) tick();
        check_quiet("reset");
        check("reset_done", int'(done_v), 0);
        check("reset_cidx", int'(cidx_v[0]) + int'(cidx_v[1]), 0);
        check("reset_cdata", int'(cdata_v[0]) + int'(cdata_v[1]), 0);
        clear_n = 1'b1;
        tick();

        // Test 1 with cycle-exact timing of the SETTLE_CYCLES=1 instance
        push_model();
        start = 1'b1;
        tick();
        for (int n = 1; n <= 18; n++) begin
            check($sformatf("t1_unload1_T+%0d", n), int'(u1_v[0]), int'(n >= 1 && n <= 2));
            check($sformatf("t1_unload2_T+%0d", n), int'(u2_v[0]), int'(n >= 3 && n <= 4));
            check($sformatf("t1_unload3_T+%0d", n), int'(u3_v[0]), int'(n >= 5 && n <= 6));
            check($sformatf("t1_valid_T+%0d", n), int'(valid_v[0]), int'(n >= 7 && n <= 15));
            check($sformatf("t1_busy_T+%0d", n), int'(busy_v[0]), int'(n <= 15));
            check($sformatf("t1_done_T+%0d", n), int'(done_v[0]), int'(n >= 16));
            tick();
        end
        wait_done();

        // Test 2: maximum operands
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                W[i][j] = 4'd15;
                X[i][j] = 4'd15;
            end
        run_one();

        // Test 3: identity W, X=1..9, ready 1,0,0 pattern
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                W[i][j] = 4'(i == j);
                X[i][j] = 4'(3 * i + j + 1);
            end
        rcnt       = 0;
        ready_mode = 1;
        run_one();
        ready_mode = 0;

        // Test 4: reset during STEP2, restart with start still high
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                W[i][j] = 4'($urandom);
                X[i][j] = 4'($urandom);
            end
        start = 1'b1;
        repeat (4) tick();
        check("t4_in_step2", int'(u2_v[0]), 1);
        clear_n = 1'b0;
        #1;
        check_quiet("t4_abort");
        exp_q[0].delete();
        exp_q[1].delete();
        tick();
        clear_n = 1'b1;
        push_model();
        wait_done();

        // Test 5: start held high must not relaunch; re-run must not carry sums
        for (int n = 0; n < 10; n++) begin
            check_quiet("t5_hold");
            check("t5_hold_done", int'(done_v), 3);
            tick();
        end
        run_one();

        // Randomized runs with random backpressure
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    W[i][j] = 4'($urandom);
                    X[i][j] = 4'($urandom);
                end
            run_one();
        end
        ready_mode = 0;
        start = 1'b0;
        repeat (3) tick();
        check_quiet("final_idle");
        check("final_done", int'(done_v), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
